// File: rtl/p_hardisc.sv
// p_hardisc: shared fetch-path definitions used by FE, the fetch buffer and ID.
package p_hardisc;
   localparam int IFB_WIDTH     = 38;
   localparam int IFB_INSTR_LSB = 0;
   localparam int IFB_FSTAT_LSB = 32;
   localparam int IFB_PRED_BIT  = 35;
   localparam int IFB_RPI_LSB   = 36;
   localparam logic [2:0] FETCH_VALID = 3'd0;
   localparam logic [2:0] FETCH_BSERR = 3'd1;
   localparam logic [2:0] FETCH_INCER = 3'd2;
   localparam logic [2:0] FETCH_UCERR = 3'd3;
   typedef logic [IFB_WIDTH-1:0] ifb_entry;
endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: fall-through instruction FIFO between FE and ID that stops
// accepting pushes after a faulty fetch until flushed.
module fetch_buffer
   import p_hardisc::*;
#(
   parameter int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic                 s_clk_i,
   input  logic                 s_rst_i,
   input  logic                 s_flush_i,
   input  logic                 s_push_i,
   input  logic [IFB_WIDTH-1:0] s_push_data_i,
   input  logic                 s_pop_i,
   output logic [IFB_WIDTH-1:0] s_head_o,
   output logic                 s_empty_o,
   output logic                 s_full_o,
   output logic                 s_afull_o,
   output logic [PTR_W:0]       s_count_o,
   output logic                 s_blocked_o,
   output logic                 s_drop_o
);
   ifb_entry         mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [PTR_W:0]   count;
   logic             blocked, drop, pop_ok, push_ok;

   assign s_empty_o   = count == '0;
   assign s_full_o    = count == (PTR_W+1)'(DEPTH);
   assign s_afull_o   = count == (PTR_W+1)'(DEPTH - 1);
   assign s_count_o   = count;
   assign s_blocked_o = blocked;
   assign s_drop_o    = drop;
   assign s_head_o    = s_empty_o ? '0 : mem[rd_ptr];
   assign pop_ok      = s_pop_i && !s_empty_o;
   assign push_ok     = s_push_i && !blocked && (!s_full_o || pop_ok);

   always_ff @(posedge s_clk_i or posedge s_rst_i)
      if (s_rst_i) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         blocked <= 1'b0;
         drop    <= 1'b0;
      end else if (s_flush_i) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         blocked <= 1'b0;
         drop    <= 1'b0;
      end else begin
         wr_ptr  <= push_ok ? wr_ptr + 1'b1 : wr_ptr;
         rd_ptr  <= pop_ok ? rd_ptr + 1'b1 : rd_ptr;
         count   <= (push_ok && !pop_ok) ? count + 1'b1 : (!push_ok && pop_ok) ? count - 1'b1 : count;
         blocked <= blocked || (push_ok && s_push_data_i[IFB_FSTAT_LSB +: 3] != FETCH_VALID);
         drop    <= s_push_i && !push_ok;
      end

   // storage needs no reset: s_head_o is masked while empty
   always_ff @(posedge s_clk_i)
      if (push_ok && !s_flush_i) mem[wr_ptr] <= s_push_data_i;

   always @(posedge s_clk_i)
      if (!s_rst_i)
         assert (count[PTR_W-1:0] == PTR_W'(wr_ptr - rd_ptr) && count <= (PTR_W+1)'(DEPTH))
            else $error("fetch_buffer: count/pointer invariant broken");
endmodule

// File: tb/tb_fetch_buffer.sv
// tb_fetch_buffer: scoreboard bench for fetch_buffer at DEPTH=4.
module tb_fetch_buffer;
   import p_hardisc::*;
   logic                 clk = 1'b0, rst = 1'b1, flush = 1'b0, push = 1'b0, pop = 1'b0;
   logic [IFB_WIDTH-1:0] data = '0, head;
   logic                 empty, full, afull, blocked, drop;
   logic [2:0]           count;
   logic [IFB_WIDTH-1:0] q[$];
   logic                 mblk = 1'b0, exp_drop = 1'b0;
   int                   n_pass = 0, n_total = 0;

   fetch_buffer #(.DEPTH(4)) dut (
      .s_clk_i(clk), .s_rst_i(rst), .s_flush_i(flush), .s_push_i(push),
      .s_push_data_i(data), .s_pop_i(pop), .s_head_o(head), .s_empty_o(empty),
      .s_full_o(full), .s_afull_o(afull), .s_count_o(count),
      .s_blocked_o(blocked), .s_drop_o(drop)
   );

   always #5 clk = ~clk;

   function automatic logic [IFB_WIDTH-1:0] ent(input logic [31:0] w, input logic [2:0] st);
      return {2'b00, 1'b0, st, w};
   endfunction

   // drives one cycle and advances the reference model; no comparisons here
   task automatic cyc(input logic p, input logic [IFB_WIDTH-1:0] d, input logic o, input logic f);
      logic pop_ok, push_ok;
      pop_ok  = o && q.size() > 0;
      push_ok = p && !mblk && (q.size() < 4 || pop_ok);
      push = p; data = d; pop = o; flush = f;
      @(posedge clk); #1;
      push = 1'b0; pop = 1'b0; flush = 1'b0;
      if (f) begin
         q.delete();
         mblk = 1'b0;
         exp_drop = 1'b0;
      end else begin
         exp_drop = p && !push_ok;
         if (pop_ok) void'(q.pop_front());
         if (push_ok) begin
            q.push_back(d);
            if (d[IFB_FSTAT_LSB +: 3] != FETCH_VALID) mblk = 1'b1;
         end
      end
   endtask

   task automatic test_reset;
      #12;
      n_total++; if (empty !== 1'b1) $display("FAIL reset_empty got %b want 1", empty); else n_pass++;
      n_total++; if (full !== 1'b0 || afull !== 1'b0) $display("FAIL reset_full got %b%b want 00", full, afull); else n_pass++;
      n_total++; if (count !== 3'd0) $display("FAIL reset_count got %0d want 0", count); else n_pass++;
      n_total++; if (head !== '0) $display("FAIL reset_head got %h want 0", head); else n_pass++;
      n_total++; if (blocked !== 1'b0 || drop !== 1'b0) $display("FAIL reset_blk_drop got %b%b want 00", blocked, drop); else n_pass++;
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_fill_drain;
      logic [31:0] w [4] = '{32'h00000013, 32'h00100093, 32'h00200113, 32'h00300193};
      for (int i = 0; i < 4; i++) begin
         cyc(1'b1, ent(w[i], FETCH_VALID), 1'b0, 1'b0);
         if (i == 2) begin
            n_total++; if (afull !== 1'b1) $display("FAIL fill_afull got %b want 1", afull); else n_pass++;
         end
      end
      n_total++; if (full !== 1'b1) $display("FAIL fill_full got %b want 1", full); else n_pass++;
      n_total++; if (count !== 3'(q.size())) $display("FAIL fill_count got %0d want %0d", count, q.size()); else n_pass++;
      for (int i = 0; i < 4; i++) begin
         n_total++; if (head !== q[0]) $display("FAIL drain_head%0d got %h want %h", i, head, q[0]); else n_pass++;
         cyc(1'b0, '0, 1'b1, 1'b0);
      end
      n_total++; if (empty !== 1'b1 || head !== '0) $display("FAIL drain_empty got %b/%h want 1/0", empty, head); else n_pass++;
   endtask

   task automatic test_overflow;
      logic [31:0] w [4] = '{32'h00000013, 32'h00100093, 32'h00200113, 32'h00300193};
      for (int i = 0; i < 4; i++) cyc(1'b1, ent(w[i], FETCH_VALID), 1'b0, 1'b0);
      cyc(1'b1, ent(32'hDEADBEEF, FETCH_VALID), 1'b0, 1'b0);
      n_total++; if (drop !== exp_drop || drop !== 1'b1) $display("FAIL ovf_drop got %b want 1", drop); else n_pass++;
      n_total++; if (count !== 3'(q.size())) $display("FAIL ovf_count got %0d want %0d", count, q.size()); else n_pass++;
      n_total++; if (head !== q[0]) $display("FAIL ovf_head got %h want %h", head, q[0]); else n_pass++;
   endtask

   task automatic test_push_pop_full;
      cyc(1'b1, ent(32'h00400213, FETCH_VALID), 1'b1, 1'b0);
      n_total++; if (count !== 3'(q.size())) $display("FAIL pp_count got %0d want %0d", count, q.size()); else n_pass++;
      n_total++; if (drop !== 1'b0) $display("FAIL pp_drop got %b want 0", drop); else n_pass++;
      for (int i = 0; i < 4; i++) begin
         n_total++; if (head !== q[0]) $display("FAIL pp_head%0d got %h want %h", i, head, q[0]); else n_pass++;
         cyc(1'b0, '0, 1'b1, 1'b0);
      end
   endtask

   task automatic test_block;
      cyc(1'b1, ent(32'h00000073, FETCH_BSERR), 1'b0, 1'b0);
      n_total++; if (blocked !== 1'b1) $display("FAIL blk_set got %b want 1", blocked); else n_pass++;
      cyc(1'b1, ent(32'h00500293, FETCH_VALID), 1'b0, 1'b0);
      n_total++; if (drop !== exp_drop || drop !== 1'b1) $display("FAIL blk_drop got %b want 1", drop); else n_pass++;
      n_total++; if (count !== 3'(q.size())) $display("FAIL blk_count got %0d want %0d", count, q.size()); else n_pass++;
      n_total++; if (head[34:32] !== 3'd1 || head !== q[0]) $display("FAIL blk_head got %h want %h", head, q[0]); else n_pass++;
      cyc(1'b0, '0, 1'b1, 1'b0);
      n_total++; if (empty !== 1'b1 || blocked !== 1'b1) $display("FAIL blk_after_pop got %b%b want 11", empty, blocked); else n_pass++;
   endtask

   task automatic test_flush;
      cyc(1'b0, '0, 1'b0, 1'b1);
      cyc(1'b1, ent(32'h00600313, FETCH_VALID), 1'b0, 1'b0);
      cyc(1'b1, ent(32'h00700393, FETCH_VALID), 1'b0, 1'b0);
      cyc(1'b1, ent(32'h00800413, FETCH_INCER), 1'b0, 1'b0);
      n_total++; if (count !== 3'd3 || blocked !== 1'b1) $display("FAIL fl_pre got %0d/%b want 3/1", count, blocked); else n_pass++;
      cyc(1'b1, ent(32'h00900493, FETCH_VALID), 1'b1, 1'b1);
      n_total++; if (count !== 3'd0 || empty !== 1'b1) $display("FAIL fl_count got %0d/%b want 0/1", count, empty); else n_pass++;
      n_total++; if (blocked !== 1'b0 || drop !== 1'b0) $display("FAIL fl_blk_drop got %b%b want 00", blocked, drop); else n_pass++;
      cyc(1'b1, ent(32'h00a00513, FETCH_VALID), 1'b0, 1'b0);
      n_total++; if (count !== 3'(q.size()) || head !== q[0]) $display("FAIL fl_push got %0d/%h want %0d/%h", count, head, q.size(), q[0]); else n_pass++;
   endtask

   task automatic test_async_reset;
      cyc(1'b1, ent(32'h00b00593, FETCH_VALID), 1'b0, 1'b0);
      n_total++; if (count !== 3'd2) $display("FAIL ar_pre got %0d want 2", count); else n_pass++;
      rst = 1'b1;
      #1;
      n_total++; if (count !== 3'd0 || empty !== 1'b1 || full !== 1'b0 || afull !== 1'b0) $display("FAIL ar_count got %0d/%b want 0/1", count, empty); else n_pass++;
      n_total++; if (head !== '0 || blocked !== 1'b0 || drop !== 1'b0) $display("FAIL ar_head got %h/%b%b want 0/00", head, blocked, drop); else n_pass++;
      #2 rst = 1'b0;
      q.delete();
      mblk = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back;
      cyc(1'b1, ent(32'h10000000, FETCH_VALID), 1'b0, 1'b0);
      for (int i = 1; i <= 10; i++) begin
         n_total++; if (head !== q[0]) $display("FAIL wrap_head%0d got %h want %h", i, head, q[0]); else n_pass++;
         cyc(1'b1, ent(32'h10000000 + 32'(i), FETCH_VALID), 1'b1, 1'b0);
      end
      n_total++; if (head !== q[0] || count !== 3'd1) $display("FAIL wrap_last got %h/%0d want %h/1", head, count, q[0]); else n_pass++;
      cyc(1'b0, '0, 1'b1, 1'b0);
      cyc(1'b0, '0, 1'b1, 1'b0);
      n_total++; if (empty !== 1'b1 || count !== 3'd0) $display("FAIL wrap_empty_pop got %b/%0d want 1/0", empty, count); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_fill_drain();
      test_overflow();
      test_push_pop_full();
      test_block();
      test_flush();
      test_async_reset();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
